// File: rtl/wtm_mac_4bit.sv
// wtm_mac_4bit: 4x4 Wallace-tree multiply-accumulate engine for dot-product jobs.
module wtm_mac_4bit #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
  endfunction

  logic [1:0] state, state_nx;
  logic [LEN_W:0] rem;
  logic [7:0] prod, prod_q, row_x, row_y;
  logic prod_v, ovf_q, hs, acc_c;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [1:0] h1, f2, f3, f4, h5, g2, t3, u4, u5, u6;

  // First reduction layer: 16 partial-product bits down to at most 3 per column
  assign h1 = ha(a[0] & b[1], a[1] & b[0]);
  assign f2 = fa(a[0] & b[2], a[1] & b[1], a[2] & b[0]);
  assign f3 = fa(a[0] & b[3], a[1] & b[2], a[2] & b[1]);
  assign f4 = fa(a[1] & b[3], a[2] & b[2], a[3] & b[1]);
  assign h5 = ha(a[2] & b[3], a[3] & b[2]);
  // Second layer leaves two rows; a[3]&b[0] and a[3]&b[3] were carried over untouched
  assign g2 = ha(h1[1], f2[0]);
  assign t3 = fa(f2[1], f3[0], a[3] & b[0]);
  assign u4 = ha(f3[1], f4[0]);
  assign u5 = ha(f4[1], h5[0]);
  assign u6 = ha(h5[1], a[3] & b[3]);
  assign row_x = {u6[1], u6[0], u5[0], u4[0], t3[0], g2[0], h1[0], a[0] & b[0]};
  assign row_y = {1'b0, u5[1], u4[1], t3[1], g2[1], 3'b000};

  // Final carry-propagate ripple adder of the two reduced rows
  always_comb begin
    logic c;
    c = 1'b0;
    prod = '0;
    for (int i = 0; i < 8; i++) {c, prod[i]} = fa(row_x[i], row_y[i], c);
  end

  assign hs = in_valid & in_ready;
  assign {acc_c, acc_nx} = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_q};

  // Next-state: DRAIN is a single cycle so the last captured product lands before DONE
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? RUN : IDLE;
    else if (state == RUN) state_nx = (hs && rem == (LEN_W + 1)'(1)) ? DRAIN : RUN;
    else if (state == DRAIN) state_nx = DONE;
    else state_nx = out_ready ? IDLE : DONE;
  end

  // Job state, pair counter, product pipeline register and sticky-overflow accumulator
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      prod_v <= hs;
      if (hs) prod_q <= prod;
      if (state == IDLE && start) begin
        rem   <= {len == '0, len};
        acc   <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (hs) rem <= rem - 1'b1;
        if (prod_v) begin
          acc   <= acc_nx;
          ovf_q <= ovf_q | acc_c;
        end
      end
    end

  assign in_ready  = state == RUN;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign sum       = acc;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_wtm_mac_4bit.sv
// tb_wtm_mac_4bit: directed self-checking bench for the Wallace-tree MAC (ACC_W=12 and ACC_W=8 instances).
module tb_wtm_mac_4bit;
  logic clk, rst_n, start, in_valid, out_ready;
  logic [3:0] len, a, b;
  logic in_ready, out_valid, ovf, busy;
  logic [11:0] sum;
  logic in_ready8, out_valid8, ovf8, busy8;
  logic [7:0] sum8;
  int checks = 0;
  int errors = 0;

  wtm_mac_4bit #(.ACC_W(12), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf), .busy(busy)
  );

  wtm_mac_4bit #(.ACC_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8), .ovf(ovf8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [3:0] l);
    start = 1'b1;
    len = l;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic [3:0] x, input logic [3:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    step();
    step();
    rst_n = 1'b1;

    // len=3, no bubbles: pairs on edges 1..3, DRAIN edge 4, result visible after it
    start_job(3);
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 1);
    push(3, 4);
    push(15, 15);
    push(0, 9);
    chk("drain_in_ready", in_ready, 0);
    chk("drain_out_valid", out_valid, 0);
    step();
    chk("j1_out_valid", out_valid, 1);
    chk("j1_sum", sum, 237);
    chk("j1_ovf", ovf, 0);
    finish_job();
    chk("j1_idle_busy", busy, 0);
    chk("j1_idle_out_valid", out_valid, 0);
    chk("j1_idle_sum", sum, 237);

    // len=0 means 16 pairs; extra valid pair during DRAIN must be refused
    start_job(0);
    for (int i = 0; i < 16; i++) push(15, 15);
    chk("j2_in_ready_after16", in_ready, 0);
    a = 15; b = 15; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("j2_out_valid", out_valid, 1);
    chk("j2_sum", sum, 3600);
    chk("j2_ovf", ovf, 0);
    finish_job();

    // bubbles between pairs hold the count
    start_job(2);
    push(7, 8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("j3_bubble_in_ready", in_ready, 1);
    end
    push(2, 5);
    step();
    chk("j3_out_valid", out_valid, 1);
    chk("j3_sum", sum, 66);
    finish_job();

    // result held under backpressure, start ignored in DONE
    start_job(1);
    push(4, 5);
    step();
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      len = 3;
      step();
      chk("j4_hold_valid", out_valid, 1);
      chk("j4_hold_sum", sum, 20);
    end
    start = 1'b0;
    finish_job();
    chk("j4_idle_busy", busy, 0);
    chk("j4_idle_out_valid", out_valid, 0);

    // mid-job asynchronous reset
    start_job(5);
    push(1, 2);
    push(3, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_ovf", ovf, 0);
    #1 rst_n = 1'b1;
    start_job(1);
    chk("post_rst_busy", busy, 1);
    push(9, 9);
    step();
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_sum", sum, 81);
    finish_job();

    // mixed products
    start_job(4);
    push(5, 3);
    push(6, 9);
    push(10, 11);
    push(13, 7);
    step();
    chk("j6_sum", sum, 270);
    finish_job();

    // narrow accumulator wraps and sets sticky ovf; wide one does not
    start_job(2);
    push(15, 15);
    push(15, 15);
    step();
    chk("w8_out_valid", out_valid8, 1);
    chk("w8_sum", sum8, 194);
    chk("w8_ovf", ovf8, 1);
    chk("w12_sum", sum, 450);
    chk("w12_ovf", ovf, 0);
    finish_job();
    chk("w8_idle_ovf", ovf8, 1);
    chk("w8_idle_busy", busy8, 0);
    start_job(1);
    chk("w8_start_clears_ovf", ovf8, 0);
    chk("w8_start_clears_sum", sum8, 0);
    chk("w8_in_ready", in_ready8, 1);
    push(1, 1);
    step();
    chk("w8_after_sum", sum8, 1);
    chk("w8_after_ovf", ovf8, 0);
    finish_job();

    // every operand pair through the multiplier
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        start_job(1);
        push(4'(x), 4'(y));
        step();
        chk($sformatf("prod_%0dx%0d", x, y), sum, x * y);
        finish_job();
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
